// File: rtl/node_pkt_injector_if.sv
// Host write port and A-interface (pkt_in) handshake bundle for node_pkt_injector.
// master = injector side (transmit end of pkt_in), slave = host/node side.
interface node_pkt_injector_if;
    logic       wr_vld;
    logic       wr_rdy;
    logic       wr_qos;
    logic [1:0] wr_type;
    logic [5:0] wr_tgt;
    logic [7:0] wr_data;

    logic       pkt_in_vld;
    logic       pkt_in_rdy;
    logic       pkt_in_qos;
    logic [1:0] pkt_in_type;
    logic [5:0] pkt_in_src;
    logic [5:0] pkt_in_tgt;
    logic [7:0] pkt_in_data;

    modport master (
        input  wr_vld, wr_qos, wr_type, wr_tgt, wr_data, pkt_in_rdy,
        output wr_rdy, pkt_in_vld, pkt_in_qos, pkt_in_type, pkt_in_src,
               pkt_in_tgt, pkt_in_data
    );

    modport slave (
        output wr_vld, wr_qos, wr_type, wr_tgt, wr_data, pkt_in_rdy,
        input  wr_rdy, pkt_in_vld, pkt_in_qos, pkt_in_type, pkt_in_src,
               pkt_in_tgt, pkt_in_data
    );
endinterface

// File: rtl/node_pkt_injector.sv
// Local traffic source for a mesh node: two QoS queues, starvation-limited arbiter, one output slot.
// Optional INJ_TGT_CHECK_EN: drop unicast writes aimed at the failed node or at this node itself.
module node_pkt_injector #(
    parameter int unsigned HP         = 0,
    parameter int unsigned VP         = 0,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                         node_clk,
    input  logic                         rst_n,
    input  logic                         pg_en,
    input  logic [5:0]                   pg_node,
    node_pkt_injector_if.master          bus,
    output logic [$clog2(DEPTH+1)-1:0]   hi_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   lo_cnt,
    output logic [7:0]                   drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIM);

    typedef struct packed {
        logic [1:0] ptype;
        logic [5:0] tgt;
        logic [7:0] data;
    } entry_t;

    entry_t          hi_mem [DEPTH];
    entry_t          lo_mem [DEPTH];
    logic [AW-1:0]   hi_wp, hi_rp, lo_wp, lo_rp;
    logic [3:0]      starve_cnt, starve_nxt;
    logic [CW-1:0]   hi_cnt_nxt, lo_cnt_nxt;

    logic   hi_full_c, lo_full_c, hi_ne_c, lo_ne_c;
    logic   drop_c, wr_fire_c, push_hi_c, push_lo_c;
    logic   slot_free_c, pick_lo_c, grant_hi_c, grant_lo_c;
    entry_t wr_e_c, pop_e_c;

    assign hi_full_c   = (hi_cnt == CW'(DEPTH));
    assign lo_full_c   = (lo_cnt == CW'(DEPTH));
    assign hi_ne_c     = (hi_cnt != '0);
    assign lo_ne_c     = (lo_cnt != '0);

    // Dropped writes are always accepted so a blocked target never stalls the host.
    assign bus.wr_rdy  = drop_c || !(bus.wr_qos ? hi_full_c : lo_full_c);
    assign wr_fire_c   = bus.wr_vld && bus.wr_rdy;
    assign push_hi_c   = wr_fire_c && !drop_c && bus.wr_qos;
    assign push_lo_c   = wr_fire_c && !drop_c && !bus.wr_qos;
    assign wr_e_c      = '{ptype: bus.wr_type, tgt: bus.wr_tgt, data: bus.wr_data};

    // Strict high priority, except low wins once high has starved it STARVE_LIM times.
    assign slot_free_c = !bus.pkt_in_vld || bus.pkt_in_rdy;
    assign pick_lo_c   = lo_ne_c && (!hi_ne_c || (starve_cnt == STARVE_MAX));
    assign grant_lo_c  = slot_free_c && pick_lo_c;
    assign grant_hi_c  = slot_free_c && hi_ne_c && !pick_lo_c;
    assign pop_e_c     = grant_lo_c ? lo_mem[lo_rp] : hi_mem[hi_rp];

    assign bus.pkt_in_src = {3'(VP), 3'(HP)};

    always_comb begin
        hi_cnt_nxt = hi_cnt;
        lo_cnt_nxt = lo_cnt;
        starve_nxt = starve_cnt;
        if (push_hi_c && !grant_hi_c)
            hi_cnt_nxt = hi_cnt + CW'(1);
        else if (!push_hi_c && grant_hi_c)
            hi_cnt_nxt = hi_cnt - CW'(1);
        if (push_lo_c && !grant_lo_c)
            lo_cnt_nxt = lo_cnt + CW'(1);
        else if (!push_lo_c && grant_lo_c)
            lo_cnt_nxt = lo_cnt - CW'(1);
        if (grant_hi_c && lo_ne_c)
            starve_nxt = starve_cnt + 4'd1;
        else if (grant_hi_c || grant_lo_c)
            starve_nxt = '0;
    end

    // Queue storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge node_clk) begin
        if (push_hi_c) hi_mem[hi_wp] <= wr_e_c;
        if (push_lo_c) lo_mem[lo_wp] <= wr_e_c;
    end

    always_ff @(posedge node_clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_wp      <= '0;
            hi_rp      <= '0;
            lo_wp      <= '0;
            lo_rp      <= '0;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            starve_cnt <= '0;
        end else begin
            if (push_hi_c)  hi_wp <= hi_wp + AW'(1);
            if (push_lo_c)  lo_wp <= lo_wp + AW'(1);
            if (grant_hi_c) hi_rp <= hi_rp + AW'(1);
            if (grant_lo_c) lo_rp <= lo_rp + AW'(1);
            hi_cnt     <= hi_cnt_nxt;
            lo_cnt     <= lo_cnt_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Output slot: loads on a grant, empties when freed with nothing to grant, holds otherwise.
    always_ff @(posedge node_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pkt_in_vld  <= 1'b0;
            bus.pkt_in_qos  <= 1'b0;
            bus.pkt_in_type <= '0;
            bus.pkt_in_tgt  <= '0;
            bus.pkt_in_data <= '0;
        end else if (grant_hi_c || grant_lo_c) begin
            bus.pkt_in_vld  <= 1'b1;
            bus.pkt_in_qos  <= grant_hi_c;
            bus.pkt_in_type <= pop_e_c.ptype;
            bus.pkt_in_tgt  <= pop_e_c.tgt;
            bus.pkt_in_data <= pop_e_c.data;
        end else if (slot_free_c) begin
            bus.pkt_in_vld  <= 1'b0;
        end
    end

`ifdef INJ_TGT_CHECK_EN
    localparam logic [5:0] SELF_ID = {3'(VP), 3'(HP)};

    assign drop_c = (bus.wr_type == 2'b00) &&
                    ((pg_en && (bus.wr_tgt == pg_node)) || (bus.wr_tgt == SELF_ID));

    always_ff @(posedge node_clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (bus.wr_vld && drop_c && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    logic unused_c;

    assign drop_c   = 1'b0;
    assign drop_cnt = 8'h00;
    assign unused_c = ^{pg_en, pg_node};
`endif

endmodule
